// File: rtl/cache_axi_arbiter_pkg.sv
// Shared state encoding, default AXI IDs and AXI3 burst/size constants for cache_axi_arbiter.
package cache_axi_arbiter_pkg;

    typedef enum logic [2:0] {
        StIdle = 3'd0,
        StIAr  = 3'd1,
        StIR   = 3'd2,
        StDAr  = 3'd3,
        StDR   = 3'd4,
        StDAw  = 3'd5,
        StDB   = 3'd6,
        StDone = 3'd7
    } arb_state_e;

    localparam logic [3:0] InstIdDefault = 4'd0;
    localparam logic [3:0] DataIdDefault = 4'd1;

    localparam logic [3:0] AxiLenSingle  = 4'd0;
    localparam logic [1:0] AxiBurstIncr  = 2'b01;
    localparam logic [2:0] AxiSizeWord   = 3'd2;

    // Cache-side size code (0=byte,1=half,2=word) maps directly onto AxSIZE.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/cache_axi_arbiter.sv
// Serves I-cache and D-cache misses over one single-beat AXI3 master port, data has priority.
// Optional build macro ARB_WAIT_BRESP_EN: wait for the B response before signalling write done.
module cache_axi_arbiter
    import cache_axi_arbiter_pkg::*;
#(
    parameter logic [3:0] INST_ID = InstIdDefault,
    parameter logic [3:0] DATA_ID = DataIdDefault
) (
    input  logic        clk,
    input  logic        resetn,

    input  logic        inst_cache_req,
    input  logic [31:0] inst_cache_addr,
    output logic [31:0] inst_cache_rdata,
    output logic        inst_cache_dok,

    input  logic        data_cache_req,
    input  logic        data_cache_wr,
    input  logic [1:0]  data_cache_size,
    input  logic [31:0] data_cache_addr,
    input  logic [3:0]  data_cache_wstrb,
    input  logic [31:0] data_cache_wdata,
    output logic [31:0] data_cache_rdata,
    output logic        data_cache_dok,

    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,

    input  logic [31:0] rdata,
    input  logic        rvalid,
    output logic        rready,

    output logic [3:0]  awid,
    output logic [31:0] awaddr,
    output logic [3:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,

    output logic [3:0]  wid,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,

    input  logic        bvalid,
    output logic        bready
);

    arb_state_e  state_q;
    logic        owner_q;   // 1 = data cache owns the current transfer
    logic [31:0] addr_q;
    logic [2:0]  size_q;
    logic [3:0]  wstrb_q;
    logic [31:0] wdata_q;
    logic        arvalid_q, rready_q, awvalid_q, wvalid_q;
    logic        aw_done_q, w_done_q;
    logic        inst_dok_q, data_dok_q;
    logic [31:0] inst_rdata_q, data_rdata_q;

    logic aw_fin, w_fin;
    assign aw_fin = aw_done_q | (awvalid_q & awready);
    assign w_fin  = w_done_q  | (wvalid_q & wready);

`ifdef ARB_WAIT_BRESP_EN
    logic bready_q;
    assign bready = bready_q;
`else
    logic unused_bvalid;
    assign unused_bvalid = bvalid;
    assign bready        = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= StIdle;
            owner_q      <= 1'b0;
            addr_q       <= '0;
            size_q       <= '0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            inst_dok_q   <= 1'b0;
            data_dok_q   <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
`ifdef ARB_WAIT_BRESP_EN
            bready_q     <= 1'b0;
`endif
        end else begin
            inst_dok_q <= 1'b0;
            data_dok_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (data_cache_req) begin
                        owner_q <= 1'b1;
                        addr_q  <= data_cache_addr;
                        size_q  <= axi_size(data_cache_size);
                        wstrb_q <= data_cache_wstrb;
                        wdata_q <= data_cache_wdata;
                        if (data_cache_wr) begin
                            state_q   <= StDAw;
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                        end else begin
                            state_q   <= StDAr;
                            arvalid_q <= 1'b1;
                        end
                    end else if (inst_cache_req) begin
                        owner_q   <= 1'b0;
                        addr_q    <= inst_cache_addr;
                        size_q    <= AxiSizeWord;
                        state_q   <= StIAr;
                        arvalid_q <= 1'b1;
                    end
                end
                StIAr, StDAr: begin
                    if (arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= (state_q == StIAr) ? StIR : StDR;
                    end
                end
                StIR, StDR: begin
                    if (rvalid) begin
                        rready_q <= 1'b0;
                        state_q  <= StDone;
                        if (owner_q) begin
                            data_rdata_q <= rdata;
                            data_dok_q   <= 1'b1;
                        end else begin
                            inst_rdata_q <= rdata;
                            inst_dok_q   <= 1'b1;
                        end
                    end
                end
                StDAw: begin
                    if (awready) awvalid_q <= 1'b0;
                    if (wready)  wvalid_q  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
`ifdef ARB_WAIT_BRESP_EN
                        state_q   <= StDB;
                        bready_q  <= 1'b1;
`else
                        state_q    <= StDone;
                        data_dok_q <= 1'b1;
`endif
                    end else begin
                        aw_done_q <= aw_fin;
                        w_done_q  <= w_fin;
                    end
                end
`ifdef ARB_WAIT_BRESP_EN
                StDB: begin
                    if (bvalid) begin
                        bready_q   <= 1'b0;
                        state_q    <= StDone;
                        data_dok_q <= 1'b1;
                    end
                end
`endif
                // Requests are deliberately not sampled here so a held req is not re-served.
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    assign inst_cache_rdata = inst_rdata_q;
    assign inst_cache_dok   = inst_dok_q;
    assign data_cache_rdata = data_rdata_q;
    assign data_cache_dok   = data_dok_q;

    assign arid    = owner_q ? DATA_ID : INST_ID;
    assign araddr  = addr_q;
    assign arlen   = AxiLenSingle;
    assign arsize  = size_q;
    assign arburst = AxiBurstIncr;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign arvalid = arvalid_q;
    assign rready  = rready_q;

    assign awid    = DATA_ID;
    assign awaddr  = addr_q;
    assign awlen   = AxiLenSingle;
    assign awsize  = size_q;
    assign awburst = AxiBurstIncr;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign awvalid = awvalid_q;

    assign wid    = DATA_ID;
    assign wdata  = wdata_q;
    assign wstrb  = wstrb_q;
    assign wlast  = 1'b1;
    assign wvalid = wvalid_q;

endmodule
